seg7_scan_driver: RTL and testbench

//  Downstream display stage of Top. Consumes the 32-bit Instruction word from the datapath
//  and time-multiplexes it as 8 hex digits onto the board's 7-segment display (out7/en_out).

---
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a 32-bit word as 8 hex digits on a
// common-anode 7-segment display. A shadow copy of the word is swapped in
// only at frame boundaries, so a frame never mixes digits of two words.
// Optional anti-ghost blanking at the start of each slot is enabled by
// defining SEG7_GHOST_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned CNT_W        = 17,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Value,
  input  logic        Load,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

`ifdef SEG7_GHOST_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  logic [CNT_W-1:0] presc;
  logic [2:0]       idx;
  logic [31:0]      pending;
  logic [31:0]      shown;
  logic             pend_vld;

  logic             tick_c;
  logic             boundary_c;
  logic             blank_c;
  logic [3:0]       nib_c;
  logic [6:0]       seg_c;

  assign tick_c     = (presc == PRESC_MAX);
  assign boundary_c = tick_c && (idx == 3'd7);
  // Blanking compares in 32 bits so BLANK_CYCLES is not truncated to CNT_W.
  assign blank_c    = BLANK_EN && (32'(presc) < BLANK_CYCLES);
  assign nib_c      = shown[{idx, 2'b00} +: 4];

  // Hex nibble to active-low {a,b,c,d,e,f,g} segment pattern.
  always_comb begin
    seg_c = 7'h7F;
    case (nib_c)
      4'h0: seg_c = 7'b0000001;
      4'h1: seg_c = 7'b1001111;
      4'h2: seg_c = 7'b0010010;
      4'h3: seg_c = 7'b0000110;
      4'h4: seg_c = 7'b1001100;
      4'h5: seg_c = 7'b0100100;
      4'h6: seg_c = 7'b0100000;
      4'h7: seg_c = 7'b0001111;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0000100;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b1100000;
      4'hC: seg_c = 7'b0110001;
      4'hD: seg_c = 7'b1000010;
      4'hE: seg_c = 7'b0110000;
      4'hF: seg_c = 7'b0111000;
      default: seg_c = 7'h7F;
    endcase
  end

  // Prescaler: one tick every REFRESH_DIV cycles.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // Digit index advances once per slot and wraps 7 -> 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx <= 3'd0;
    end else if (tick_c) begin
      idx <= idx + 3'd1;
    end
  end

  // Pending/shadow word: loads collect in pending, swap in at frame boundary;
  // a load on the boundary edge bypasses straight into shown.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending  <= '0;
      shown    <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (Load) begin
        pending <= Value;
      end
      if (boundary_c) begin
        if (Load) begin
          shown <= Value;
        end else if (pend_vld) begin
          shown <= pending;
        end
        pend_vld <= 1'b0;
      end else if (Load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // Registered display outputs and frame pulse, one cycle behind idx/shown.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out7       <= 7'h7F;
      en_out     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_c;
      if (blank_c) begin
        out7   <= 7'h7F;
        en_out <= 8'hFF;
      end else begin
        out7   <= seg_c;
        en_out <= ~(8'b1 << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (32-cycle frames).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_scan_driver;

  logic        Clk;
  logic        Rst;
  logic [31:0] Value;
  logic        Load;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        frame_done;

  int n_vec;
  int n_err;

  seg7_scan_driver #(
    .REFRESH_DIV  (4),
    .CNT_W        (2),
    .BLANK_CYCLES (1)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Value      (Value),
    .Load       (Load),
    .out7       (out7),
    .en_out     (en_out),
    .frame_done (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hand-entered segment table, active-low {a..g}.
  function automatic logic [6:0] seg_exp(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive n_edges cycles of one frame starting at slot 0, checking every edge.
  // Up to two loads may be placed at frame-relative edges la/lb (-1 = none).
  task automatic run_frame(input string name, input logic [31:0] word, input int n_edges,
                           input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb);
    for (int i = 0; i < n_edges; i++) begin
      int d;
      logic [7:0] en_e;
      logic [6:0] seg_e;
      d = i / 4;
      if (i == la) begin
        Load = 1'b1; Value = va;
      end else if (i == lb) begin
        Load = 1'b1; Value = vb;
      end else begin
        Load = 1'b0; Value = 32'hDEAD_BEEF;
      end
      @(posedge Clk);
      @(negedge Clk);
      en_e  = 8'hFF;
      en_e[d] = 1'b0;
      seg_e = seg_exp(word[4*d +: 4]);
`ifdef SEG7_GHOST_BLANK_EN
      if ((i % 4) == 0) begin
        en_e  = 8'hFF;
        seg_e = 7'h7F;
      end
`endif
      check($sformatf("%s e%0d en_out", name, i), 32'(en_out), 32'(en_e));
      check($sformatf("%s e%0d out7", name, i), 32'(out7), 32'(seg_e));
      check($sformatf("%s e%0d frame_done", name, i), 32'(frame_done), 32'(i == 31));
    end
    Load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    Rst   = 1'b1;
    Load  = 1'b0;
    Value = 32'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset en_out", 32'(en_out), 32'h0000_00FF);
    check("reset out7", 32'(out7), 32'h0000_007F);
    check("reset frame_done", 32'(frame_done), 32'h0);
    Rst = 1'b0;

    // Frame 1 shows zeros; load at cycle 3 becomes visible in frame 2.
    run_frame("f1", 32'h0000_0000, 32, 2, 32'h89AB_CDEF, -1, 32'h0);
    run_frame("f2", 32'h89AB_CDEF, 32, -1, 32'h0, -1, 32'h0);
    // Two loads in one frame: last one wins at the next boundary.
    run_frame("f3", 32'h89AB_CDEF, 32, 5, 32'h1111_1111, 20, 32'h2222_2222);
    // Load coincident with the boundary edge bypasses into shown.
    run_frame("f4", 32'h2222_2222, 32, 31, 32'h0000_0007, -1, 32'h0);
    run_frame("f5", 32'h0000_0007, 32, -1, 32'h0, -1, 32'h0);
    // Reset while idx=5.
    run_frame("f6", 32'h0000_0007, 22, -1, 32'h0, -1, 32'h0);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("midrst en_out", 32'(en_out), 32'h0000_00FF);
    check("midrst out7", 32'(out7), 32'h0000_007F);
    check("midrst frame_done", 32'(frame_done), 32'h0);
    Rst = 1'b0;
    // Shown was cleared and scan restarts at digit 0 with a full-length frame.
    run_frame("f7", 32'h0000_0000, 32, -1, 32'h0, -1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
